gate_truth_table_checker: RTL and testbench

- Self-checking sequencer for the 2-input primitive gate blocks, such as the NOR variants.
- Upstream, it drives every input combination into the gate under test. Downstream, it samples the gate output and compares it against an expected truth table.
- It counts mismatches and reports pass or fail, so gate blocks can be checked on silicon or in a synthesizable BIST wrapper rather than only with a simulation monitor.

---
 rtl/gate_chk_pkg.sv | 19 +
 rtl/gate_truth_table_checker_if.sv | 36 +++
 rtl/gate_chk_settle_timer.sv | 27 ++
 rtl/gate_truth_table_checker.sv | 115 +++++++++++
 tb/tb_gate_truth_table_checker.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and truth-table constants for the 2-input gate truth-table checker.
package gate_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  // Bit i is the expected output for input vector i (i[1] drives a).
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_truth_table_checker_if.sv
// Control, status and gate-under-test signals of the truth-table checker.
// Optional first-failure capture signals exist only with GATE_CHK_FIRST_FAIL_EN.
interface gate_truth_table_checker_if #(
  parameter int N_IN  = 2,
  parameter int CNT_W = 3
);
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [N_IN-1:0]  vec_idx;
  logic [N_IN-1:0]  dut_in;
  logic             dut_out;
`ifdef GATE_CHK_FIRST_FAIL_EN
  logic [N_IN-1:0]  first_fail_idx;
  logic             first_fail_vld;
`endif

  modport master (
    input  start, dut_out,
    output busy, done, pass, err_count, vec_idx, dut_in
`ifdef GATE_CHK_FIRST_FAIL_EN
    , output first_fail_idx, first_fail_vld
`endif
  );

  modport slave (
    output start, dut_out,
    input  busy, done, pass, err_count, vec_idx, dut_in
`ifdef GATE_CHK_FIRST_FAIL_EN
    , input first_fail_idx, first_fail_vld
`endif
  );

endinterface

// File: rtl/gate_chk_settle_timer.sv
// Loadable down-counter with zero flag; paces the SETTLE state of the checker.
module gate_chk_settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_truth_table_checker.sv
// Drives every input vector into a gate under test, compares against EXPECTED and counts mismatches.
// Optional macro GATE_CHK_FIRST_FAIL_EN adds capture of the first failing vector index.
module gate_truth_table_checker
  import gate_chk_pkg::*;
#(
  parameter int                   N_IN          = 2,
  parameter logic [(2**N_IN)-1:0] EXPECTED      = TT_NOR,
  parameter int                   SETTLE_CYCLES = 2,
  parameter int                   CNT_W         = 3
) (
  input logic                      clk,
  input logic                      rst,
  gate_truth_table_checker_if.master bus
);

  localparam logic [N_IN-1:0] LAST_VEC    = '1;
  localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [N_IN-1:0]  vec_q;
  logic [CNT_W-1:0] err_q;
  logic             pass_q;
  logic             tmr_load;
  logic             tmr_zero;
  logic             mismatch;
  logic             run_start;

  gate_chk_settle_timer #(.W(8)) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .dec      (state == SETTLE),
    .zero     (tmr_zero)
  );

  assign run_start = (state == IDLE) && bus.start;
  assign mismatch  = (state == SAMPLE) && (bus.dut_out != EXPECTED[vec_q]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    case (state)
      IDLE:    if (bus.start) state_next = DRIVE;
      DRIVE: begin
        tmr_load   = 1'b1;
        state_next = SETTLE;
      end
      SETTLE:  if (tmr_zero) state_next = SAMPLE;
      SAMPLE:  state_next = (vec_q == LAST_VEC) ? DONE : DRIVE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // pass is resolved on the final SAMPLE edge so it is already valid while done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q  <= '0;
      err_q  <= '0;
      pass_q <= 1'b0;
    end else if (run_start) begin
      vec_q  <= '0;
      err_q  <= '0;
      pass_q <= 1'b0;
    end else if (state == SAMPLE) begin
      if (mismatch && err_q != '1) begin
        err_q <= err_q + CNT_W'(1);
      end
      if (vec_q != LAST_VEC) begin
        vec_q <= vec_q + N_IN'(1);
      end else begin
        pass_q <= !mismatch && (err_q == '0);
      end
    end
  end

`ifdef GATE_CHK_FIRST_FAIL_EN
  logic [N_IN-1:0] ff_idx_q;
  logic            ff_vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_idx_q <= '0;
      ff_vld_q <= 1'b0;
    end else if (run_start) begin
      ff_idx_q <= '0;
      ff_vld_q <= 1'b0;
    end else if (mismatch && !ff_vld_q) begin
      ff_idx_q <= vec_q;
      ff_vld_q <= 1'b1;
    end
  end

  assign bus.first_fail_idx = ff_idx_q;
  assign bus.first_fail_vld = ff_vld_q;
`endif

  assign bus.busy      = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);
  assign bus.done      = (state == DONE);
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.vec_idx   = vec_q;
  assign bus.dut_in    = vec_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench: five checker instances (good NOR, stuck-at-0, wrong OR, AND with short settle, saturating counter).
module tb_gate_truth_table_checker;
  import gate_chk_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] start_v;
  logic [4:0] done_v;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  gate_truth_table_checker_if #(.N_IN(2), .CNT_W(3)) if_nor   ();
  gate_truth_table_checker_if #(.N_IN(2), .CNT_W(3)) if_stuck ();
  gate_truth_table_checker_if #(.N_IN(2), .CNT_W(3)) if_or    ();
  gate_truth_table_checker_if #(.N_IN(2), .CNT_W(3)) if_and   ();
  gate_truth_table_checker_if #(.N_IN(2), .CNT_W(2)) if_sat   ();

  gate_truth_table_checker u_nor (.clk(clk), .rst(rst), .bus(if_nor.master));
  gate_truth_table_checker #(.EXPECTED(TT_NOR)) u_stuck (.clk(clk), .rst(rst), .bus(if_stuck.master));
  gate_truth_table_checker #(.EXPECTED(TT_NOR)) u_or (.clk(clk), .rst(rst), .bus(if_or.master));
  gate_truth_table_checker #(.EXPECTED(TT_AND), .SETTLE_CYCLES(1)) u_and (.clk(clk), .rst(rst), .bus(if_and.master));
  gate_truth_table_checker #(.EXPECTED(TT_NOR), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(if_sat.master));

  assign if_nor.dut_out   = ~(if_nor.dut_in[1] | if_nor.dut_in[0]);
  assign if_stuck.dut_out = 1'b0;
  assign if_or.dut_out    = if_or.dut_in[1] | if_or.dut_in[0];
  assign if_and.dut_out   = if_and.dut_in[1] & if_and.dut_in[0];
  assign if_sat.dut_out   = if_sat.dut_in[1] | if_sat.dut_in[0];

  assign if_nor.start   = start_v[0];
  assign if_stuck.start = start_v[1];
  assign if_or.start    = start_v[2];
  assign if_and.start   = start_v[3];
  assign if_sat.start   = start_v[4];
  assign done_v = {if_sat.done, if_and.done, if_or.done, if_stuck.done, if_nor.done};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one edge; cyc counts cycles after the start edge until done (capped at limit).
  task automatic run_to_done(input int idx, input int limit, output int cyc);
    @(negedge clk);
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
    cyc = 1;
    while (done_v[idx] !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int done_cnt;
    int done_at;

    rst     = 1'b1;
    start_v = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   32'(if_nor.busy), 0);
    chk("rst_done",   32'(if_nor.done), 0);
    chk("rst_pass",   32'(if_nor.pass), 0);
    chk("rst_err",    32'(if_nor.err_count), 0);
    chk("rst_vec",    32'(if_nor.vec_idx), 0);
    chk("rst_dut_in", 32'(if_nor.dut_in), 0);
`ifdef GATE_CHK_FIRST_FAIL_EN
    chk("rst_ff_vld", 32'(if_nor.first_fail_vld), 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(if_nor.busy), 0);

    // Good NOR: busy cycles 1..16, done in cycle 17, vector changes every 4 cycles
    start_v[0] = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 1) start_v[0] = 1'b0;
      chk("nor_busy", 32'(if_nor.busy), 32'(k <= 16));
      chk("nor_done", 32'(if_nor.done), 32'(k == 17));
      if (k <= 16) chk("nor_dut_in", 32'(if_nor.dut_in), 32'((k - 1) / 4));
    end
    @(negedge clk);
    chk("nor_pass",     32'(if_nor.pass), 1);
    chk("nor_err",      32'(if_nor.err_count), 0);
    chk("nor_hold_in",  32'(if_nor.dut_in), 3);
    chk("nor_hold_vec", 32'(if_nor.vec_idx), 3);
    chk("nor_idle",     32'(if_nor.busy), 0);
`ifdef GATE_CHK_FIRST_FAIL_EN
    chk("nor_ff_vld", 32'(if_nor.first_fail_vld), 0);
`endif

    // Stuck-at-0: only vector 0 (expected 1) mismatches
    run_to_done(1, 40, cyc);
    chk("stuck_done_cycle", 32'(cyc), 17);
    @(negedge clk);
    chk("stuck_err",  32'(if_stuck.err_count), 1);
    chk("stuck_pass", 32'(if_stuck.pass), 0);
`ifdef GATE_CHK_FIRST_FAIL_EN
    chk("stuck_ff_idx", 32'(if_stuck.first_fail_idx), 0);
    chk("stuck_ff_vld", 32'(if_stuck.first_fail_vld), 1);
`endif

    // OR against NOR table: all four vectors mismatch
    run_to_done(2, 40, cyc);
    chk("or_done_cycle", 32'(cyc), 17);
    @(negedge clk);
    chk("or_err",  32'(if_or.err_count), 4);
    chk("or_pass", 32'(if_or.pass), 0);
`ifdef GATE_CHK_FIRST_FAIL_EN
    chk("or_ff_idx", 32'(if_or.first_fail_idx), 0);
`endif
    // restart clears err_count on the start edge
    start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    chk("or_restart_err",  32'(if_or.err_count), 0);
    chk("or_restart_busy", 32'(if_or.busy), 1);
    cyc = 1;
    while (if_or.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("or_restart_done_cycle", 32'(cyc), 17);
    @(negedge clk);
    chk("or_restart_err_final", 32'(if_or.err_count), 4);

    // AND with SETTLE_CYCLES=1: 3-cycle period, done 13 cycles after start
    run_to_done(3, 40, cyc);
    chk("and_done_cycle", 32'(cyc), 13);
    @(negedge clk);
    chk("and_pass", 32'(if_and.pass), 1);
    chk("and_err",  32'(if_and.err_count), 0);

    // 2-bit counter saturates at 3 with four mismatches
    run_to_done(4, 40, cyc);
    chk("sat_done_cycle", 32'(cyc), 17);
    @(negedge clk);
    chk("sat_err",  32'(if_sat.err_count), 3);
    chk("sat_pass", 32'(if_sat.pass), 0);

    // start pulsed mid-run is ignored: one done pulse at cycle 17
    @(negedge clk);
    start_v[0] = 1'b1;
    done_cnt = 0;
    done_at  = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (if_nor.done === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
      start_v[0] = (k == 5);
    end
    chk("midstart_done_cnt", 32'(done_cnt), 1);
    chk("midstart_done_at",  32'(done_at), 17);
    chk("midstart_idle",     32'(if_nor.busy), 0);

    // start held across DONE->IDLE launches a new run from the first IDLE cycle
    start_v[0] = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 17) chk("held_done", 32'(if_nor.done), 1);
      if (k == 18) begin
        chk("held_idle_busy", 32'(if_nor.busy), 0);
        chk("held_idle_pass", 32'(if_nor.pass), 1);
      end
      if (k == 19) chk("held_rerun_busy", 32'(if_nor.busy), 1);
    end
    start_v[0] = 1'b0;
    cyc = 19;
    while (if_nor.done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("held_second_done", 32'(cyc), 35);
    @(negedge clk);
    chk("held_second_pass", 32'(if_nor.pass), 1);

    // reset in SETTLE of vector 2 aborts immediately, no done pulse afterwards
    start_v[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
    end
    chk("abort_pre_in",   32'(if_nor.dut_in), 2);
    chk("abort_pre_busy", 32'(if_nor.busy), 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(if_nor.busy), 0);
    chk("abort_in",   32'(if_nor.dut_in), 0);
    chk("abort_vec",  32'(if_nor.vec_idx), 0);
    chk("abort_pass", 32'(if_nor.pass), 0);
    chk("abort_done", 32'(if_nor.done), 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if_nor.done === 1'b1) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 0);
    chk("abort_stays_idle", 32'(if_nor.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
